conv_sample_loader: RTL and testbench
=====================================

# conv_sample_loader

Upstream stage of `convolution`. Accepts paired samples (a, b) as a serial valid/ready stream and assembles them into N-entry frames, zero-padding short frames. Presents each frame as flattened parallel buses to the convolution stage. Two ping-pong banks let the next frame fill while the current one is held for the convolution.

## Interface
Parameters:
- `N`, default 21: samples per frame (taps of `signal_a` / `signal_b`).
- `W`, default 21: sample width in bits.
- `CW`, default `$clog2(N+1)`: width of the frame-length field.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `s_valid`, in, 1: input beat valid.
- `s_ready`, out, 1: loader can accept a beat.
- `s_a`, in, W: sample for signal_a.
- `s_b`, in, W: sample for signal_b.
- `s_last`, in, 1: last beat of the frame.
- `f_valid`, out, 1: a complete frame is presented.
- `f_ready`, in, 1: convolution stage consumes the frame.
- `f_a`, out, N*W: frame a; entry i at `[i*W +: W]`.
- `f_b`, out, N*W: frame b; same layout as `f_a`.
- `f_len`, out, CW: beats actually received, 1..N.
- `f_short`, out, 1: frame was closed early by `s_last` (`f_len` < N).

## Operation
- Two banks, each holding N (a, b) pairs plus a length and a short flag. State per bank is `full` (1 bit).
- Write pointer `wr_ptr` and read pointer `rd_ptr` are each 1 bit and start at 0.
- Write index `wr_idx` counts 0..N-1 within the current fill bank.
- Input side:
  - A beat is accepted when `s_valid && s_ready`.
  - `s_ready = !full[wr_ptr]`.
  - An accepted beat writes entry `wr_idx` of bank `wr_ptr` and increments `wr_idx`.
- Frame close: the accepted beat closes the frame when `s_last == 1` or `wr_idx == N-1`, whichever comes first. On close:
  - `full[wr_ptr] <= 1`.
  - The bank's length is set to `wr_idx+1`.
  - The bank's short flag is set to `(wr_idx+1 < N)`.
  - `wr_ptr` toggles and `wr_idx <= 0`.
- Beats beyond N without `s_last` start a new frame. `s_last` is ignored for framing except as the early-close trigger.
- Output side:
  - `f_valid = full[rd_ptr]`.
  - `f_a`, `f_b`, `f_len`, `f_short` are driven from bank `rd_ptr` and are stable while `f_valid` is high.
  - On `f_valid && f_ready`: `full[rd_ptr] <= 0`, all N entries of that bank are cleared to 0, and `rd_ptr` toggles.
- Because a bank is cleared on release and at reset, a short frame's untouched entries read as 0 (zero padding).
- Arithmetic: samples are stored unmodified and no width conversion is done.
- Counter widths: `wr_idx` is `$clog2(N)` bits.

## Timing
- Reset values:
  - `s_ready = 1`, `f_valid = 0`.
  - `f_a = 0`, `f_b = 0`, `f_len = 0`, `f_short = 0`.
  - Both banks are zeroed; `wr_ptr = 0`, `rd_ptr = 0`, `wr_idx = 0`.
- Latency: a closing beat accepted at edge t gives `f_valid = 1` after edge t (visible in cycle t+1).
- Throughput: one beat per cycle sustained while `f_ready` keeps up. `s_ready` drops only when both banks are full.
- Release: `f_valid && f_ready` at edge t frees the bank, and `s_ready` can rise after edge t.
- Simultaneous close (bank X) and release (bank Y≠X) in one cycle: both take effect, and no beat is lost.
- When the fill bank becomes full, `s_ready` is low in the next cycle. Beats presented while `s_ready = 0` are not accepted; the source holds them.
- `f_ready` while `f_valid = 0` has no effect.
- Reset asserted mid-frame: the partial frame and any held frame are discarded, and all outputs return to their reset values immediately (asynchronously).

## Configuration
- `CONV_LOADER_STATS_EN` defined: adds outputs `stat_frames` (16-bit, count of released frames) and `stat_short` (16-bit, count of released frames with `f_short`).
  - Both saturate at 0xFFFF.
  - Both reset to 0 on `rst_n` low.
- `CONV_LOADER_STATS_EN` not defined: these ports and counters do not exist, and the remaining behaviour is identical.

## Structure
- Shared package `conv_pkg`:
  - Constants `CONV_N = 21` and `CONV_W = 21`, used as the defaults for `N` and `W`.
  - The typedef for a sample pair `{a, b}`.
- Sub-module `conv_frame_bank`, instantiated twice. It contains:
  - N×2×W storage, length and short registers.
  - Write port (index, a, b, close, len).
  - Clear-on-release input.
  - Flattened read outputs.
- The top module holds the pointers, `wr_idx`, the full flags, the handshake logic and the optional stats.

## Test plan
- Full frame: 21 beats with a=i+1, b=2i, `s_last` on beat 20, `f_ready = 0` → `f_valid` rises the cycle after beat 20; `f_a[i] = i+1`, `f_b[i] = 2i`, `f_len = 21`, `f_short = 0`.
- Short frame: 5 beats with a=b=7, `s_last` on beat 4 → `f_len = 5`, `f_short = 1`, entries 0–4 = 7, entries 5–20 = 0.
- Backpressure: 3 full frames streamed back-to-back with `f_ready = 0` → 2 frames held, `s_ready = 0` from the cycle after the 42nd beat. Then one `f_ready` pulse → `s_ready = 1` next cycle; the third frame completes with no beats lost.
- Ping-pong overlap: `f_ready = 1` constantly, continuous 63-beat stream with no `s_last` → 3 frames, in order, each `f_len = 21`; `s_ready` never drops.
- Reset mid-frame: `rst_n` low after beat 10 of frame 1 (frame 0 held) → `f_valid = 0`, `s_ready = 1`, outputs zero. A subsequent 21-beat frame is captured from index 0.
- With `CONV_LOADER_STATS_EN` defined: release 3 full + 2 short frames → `stat_frames = 5`, `stat_short = 2`.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and sample-pair type for the convolution datapath
package conv_pkg;

    localparam int CONV_N = 21;
    localparam int CONV_W = 21;

    typedef struct packed {
        logic [CONV_W-1:0] a;
        logic [CONV_W-1:0] b;
    } conv_pair_t;

endpackage

// File: rtl/conv_frame_bank.sv
// rtl/conv_frame_bank.sv - one frame buffer: N (a, b) entries plus length and short flag
module conv_frame_bank
    import conv_pkg::*;
#(
    parameter int N  = CONV_N,
    parameter int W  = CONV_W,
    parameter int CW = $clog2(N + 1),
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [IW-1:0] wr_idx_i,
    input  logic [W-1:0]  wr_a_i,
    input  logic [W-1:0]  wr_b_i,
    input  logic          wr_close_i,
    input  logic [CW-1:0] wr_len_i,
    input  logic          clr_i,
    output logic [N*W-1:0] rd_a_o,
    output logic [N*W-1:0] rd_b_o,
    output logic [CW-1:0] rd_len_o,
    output logic          rd_short_o
);

    logic [N*W-1:0] a_q, a_d;
    logic [N*W-1:0] b_q, b_d;
    logic [CW-1:0]  len_q, len_d;
    logic           short_q, short_d;

    // Clearing on release is what gives short frames their zero padding.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        len_d   = len_q;
        short_d = short_q;
        if (clr_i) begin
            a_d     = '0;
            b_d     = '0;
            len_d   = '0;
            short_d = 1'b0;
        end else if (wr_en_i) begin
            for (int i = 0; i < N; i++) begin
                if (wr_idx_i == IW'(i)) begin
                    a_d[i*W +: W] = wr_a_i;
                    b_d[i*W +: W] = wr_b_i;
                end
            end
            if (wr_close_i) begin
                len_d   = wr_len_i;
                short_d = (wr_len_i < CW'(N));
            end
        end
    end

    // Bank storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            len_q   <= '0;
            short_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            len_q   <= len_d;
            short_q <= short_d;
        end
    end

    assign rd_a_o     = a_q;
    assign rd_b_o     = b_q;
    assign rd_len_o   = len_q;
    assign rd_short_o = short_q;

endmodule

// File: rtl/conv_sample_loader.sv
// rtl/conv_sample_loader.sv - ping-pong frame loader; CONV_LOADER_STATS_EN adds release counters
module conv_sample_loader
    import conv_pkg::*;
#(
    parameter int N  = CONV_N,
    parameter int W  = CONV_W,
    parameter int CW = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_a,
    input  logic [W-1:0]   s_b,
    input  logic           s_last,
    output logic           f_valid,
    input  logic           f_ready,
    output logic [N*W-1:0] f_a,
    output logic [N*W-1:0] f_b,
    output logic [CW-1:0]  f_len,
`ifdef CONV_LOADER_STATS_EN
    output logic [15:0]    stat_frames,
    output logic [15:0]    stat_short,
`endif
    output logic           f_short
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [1:0]    full_q, full_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;

    logic          beat_acc;
    logic          frame_close;
    logic          frame_rel;
    logic [CW-1:0] close_len;

    logic [N*W-1:0] bank_a   [2];
    logic [N*W-1:0] bank_b   [2];
    logic [CW-1:0]  bank_len [2];
    logic           bank_short [2];

    assign s_ready     = !full_q[wr_ptr_q];
    assign f_valid     = full_q[rd_ptr_q];
    assign beat_acc    = s_valid && s_ready;
    assign frame_close = beat_acc && (s_last || (wr_idx_q == IW'(N - 1)));
    assign frame_rel   = f_valid && f_ready;
    assign close_len   = CW'(wr_idx_q) + CW'(1);

    // Pointer, index and full-flag updates; close and release always hit different banks.
    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_idx_d = wr_idx_q;
        if (beat_acc) begin
            if (frame_close) begin
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = ~wr_ptr_q;
                wr_idx_d         = '0;
            end else begin
                wr_idx_d = wr_idx_q + IW'(1);
            end
        end
        if (frame_rel) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            wr_idx_q <= '0;
        end else begin
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        conv_frame_bank #(
            .N  (N),
            .W  (W),
            .CW (CW),
            .IW (IW)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en_i    (beat_acc && (wr_ptr_q == 1'(g))),
            .wr_idx_i   (wr_idx_q),
            .wr_a_i     (s_a),
            .wr_b_i     (s_b),
            .wr_close_i (frame_close),
            .wr_len_i   (close_len),
            .clr_i      (frame_rel && (rd_ptr_q == 1'(g))),
            .rd_a_o     (bank_a[g]),
            .rd_b_o     (bank_b[g]),
            .rd_len_o   (bank_len[g]),
            .rd_short_o (bank_short[g])
        );
    end

    assign f_a     = bank_a[rd_ptr_q];
    assign f_b     = bank_b[rd_ptr_q];
    assign f_len   = bank_len[rd_ptr_q];
    assign f_short = bank_short[rd_ptr_q];

`ifdef CONV_LOADER_STATS_EN
    logic [15:0] stat_frames_q, stat_frames_d;
    logic [15:0] stat_short_q, stat_short_d;

    // Saturating counts of released frames and released short frames.
    always_comb begin
        stat_frames_d = stat_frames_q;
        stat_short_d  = stat_short_q;
        if (frame_rel) begin
            if (stat_frames_q != 16'hFFFF) stat_frames_d = stat_frames_q + 16'd1;
            if (f_short && (stat_short_q != 16'hFFFF)) stat_short_d = stat_short_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames_q <= '0;
            stat_short_q  <= '0;
        end else begin
            stat_frames_q <= stat_frames_d;
            stat_short_q  <= stat_short_d;
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_short  = stat_short_q;
`endif

endmodule

// File: tb/tb_conv_sample_loader.sv
// tb/tb_conv_sample_loader.sv - randomized self-checking bench for conv_sample_loader
module tb_conv_sample_loader;
    import conv_pkg::*;

    localparam int N  = CONV_N;
    localparam int W  = CONV_W;
    localparam int CW = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W-1:0]   s_a = '0;
    logic [W-1:0]   s_b = '0;
    logic           s_last = 1'b0;
    logic           f_valid;
    logic           f_ready = 1'b0;
    logic [N*W-1:0] f_a;
    logic [N*W-1:0] f_b;
    logic [CW-1:0]  f_len;
    logic           f_short;
`ifdef CONV_LOADER_STATS_EN
    logic [15:0]    stat_frames;
    logic [15:0]    stat_short;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: completed frames waiting in order, plus the frame being filled.
    logic [N*W-1:0] qa [$];
    logic [N*W-1:0] qb [$];
    int             qlen [$];
    logic [W-1:0]   cur_a [N];
    logic [W-1:0]   cur_b [N];
    int             cur_n = 0;

    conv_sample_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_a         (s_a),
        .s_b         (s_b),
        .s_last      (s_last),
        .f_valid     (f_valid),
        .f_ready     (f_ready),
        .f_a         (f_a),
        .f_b         (f_b),
        .f_len       (f_len),
`ifdef CONV_LOADER_STATS_EN
        .stat_frames (stat_frames),
        .stat_short  (stat_short),
`endif
        .f_short     (f_short)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        qa.delete();
        qb.delete();
        qlen.delete();
        for (int i = 0; i < N; i++) begin
            cur_a[i] = '0;
            cur_b[i] = '0;
        end
        cur_n = 0;
    endtask

    task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b, input bit last);
        logic [N*W-1:0] va;
        logic [N*W-1:0] vb;
        cur_a[cur_n] = a;
        cur_b[cur_n] = b;
        cur_n++;
        if (last || cur_n == N) begin
            va = '0;
            vb = '0;
            for (int i = 0; i < N; i++) begin
                va[i*W +: W] = cur_a[i];
                vb[i*W +: W] = cur_b[i];
                cur_a[i] = '0;
                cur_b[i] = '0;
            end
            qa.push_back(va);
            qb.push_back(vb);
            qlen.push_back(cur_n);
            cur_n = 0;
        end
    endtask

    // Applies one cycle of inputs, advances to the next falling edge, updates the model.
    task automatic cycle(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit last, input bit fr, output bit acc);
        bit rel;
        s_valid = v;
        s_a     = a;
        s_b     = b;
        s_last  = last;
        f_ready = fr;
        acc = v && (qa.size() < 2);
        rel = fr && (qa.size() > 0);
        @(posedge clk);
        if (rel) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
            void'(qlen.pop_front());
        end
        if (acc) model_beat(a, b, last);
        @(negedge clk);
    endtask

    task automatic idle(input bit fr);
        bit acc;
        cycle(1'b0, '0, '0, 1'b0, fr, acc);
    endtask

    // Presents a beat until accepted, within a bounded number of cycles.
    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit last, input bit fr);
        bit acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) cycle(1'b1, a, b, last, fr, acc);
        if (!acc) begin
            miscompares++;
            $display("FAIL send_beat: beat not accepted within 40 cycles");
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (s_ready !== 1'b1 || f_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: s_ready=%b f_valid=%b expected 1/0", s_ready, f_valid);
        end
        vectors++;
        if (f_a !== '0 || f_b !== '0 || f_len !== '0 || f_short !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_data: f_len=%0d f_short=%b data nonzero=%b", f_len, f_short, (f_a != 0) || (f_b != 0));
        end
        rst_n = 1'b1;
        idle(1'b1);
        vectors++;
        if (f_valid !== 1'b0 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_ready: f_valid=%b s_ready=%b expected 0/1", f_valid, s_ready);
        end
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < N; i++) begin
            send_beat(W'(i + 1), W'(2 * i), i == N - 1, 1'b0);
            vectors++;
            if (f_valid !== (i == N - 1)) begin
                miscompares++;
                $display("FAIL full_fvalid: beat %0d f_valid=%b expected %b", i, f_valid, i == N - 1);
            end
        end
        vectors++;
        if (f_a !== qa[0] || f_b !== qb[0]) begin
            miscompares++;
            $display("FAIL full_data: f_a=%h expected %h", f_a, qa[0]);
        end
        vectors++;
        if (f_a[(N-1)*W +: W] !== W'(N) || f_b[(N-1)*W +: W] !== W'(2 * (N - 1))) begin
            miscompares++;
            $display("FAIL full_last_entry: a=%0d b=%0d expected %0d %0d", f_a[(N-1)*W +: W], f_b[(N-1)*W +: W], N, 2 * (N - 1));
        end
        vectors++;
        if (f_len !== CW'(N) || f_short !== 1'b0) begin
            miscompares++;
            $display("FAIL full_len: f_len=%0d f_short=%b expected %0d 0", f_len, f_short, N);
        end
        idle(1'b1);
        vectors++;
        if (f_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_release: f_valid=%b expected 0", f_valid);
        end
    endtask

    task automatic test_short_frame();
        for (int i = 0; i < 5; i++) send_beat(W'(7), W'(7), i == 4, 1'b0);
        vectors++;
        if (f_valid !== 1'b1 || f_len !== CW'(5) || f_short !== 1'b1) begin
            miscompares++;
            $display("FAIL short_len: f_valid=%b f_len=%0d f_short=%b expected 1 5 1", f_valid, f_len, f_short);
        end
        vectors++;
        if (f_a !== qa[0] || f_b !== qb[0]) begin
            miscompares++;
            $display("FAIL short_pad: f_a=%h expected %h", f_a, qa[0]);
        end
        idle(1'b1);
    endtask

    task automatic test_backpressure();
        bit acc;
        logic [W-1:0] ha;
        logic [W-1:0] hb;
        for (int i = 0; i < 2 * N; i++) send_beat(W'($urandom), W'($urandom), 1'b0, 1'b0);
        vectors++;
        if (s_ready !== 1'b0 || f_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_stall: s_ready=%b f_valid=%b expected 0/1", s_ready, f_valid);
        end
        ha = W'($urandom);
        hb = W'($urandom);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, ha, hb, 1'b0, 1'b0, acc);
            vectors++;
            if (s_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold: s_ready=%b expected 0", s_ready);
            end
        end
        cycle(1'b1, ha, hb, 1'b0, 1'b1, acc);
        vectors++;
        if (s_ready !== 1'b1 || f_valid !== 1'b1 || f_a !== qa[0] || f_b !== qb[0]) begin
            miscompares++;
            $display("FAIL bp_release: s_ready=%b f_valid=%b f_a=%h expected 1 1 %h", s_ready, f_valid, f_a, qa[0]);
        end
        send_beat(ha, hb, 1'b0, 1'b0);
        for (int i = 1; i < N; i++) send_beat(W'($urandom), W'($urandom), 1'b0, 1'b0);
        for (int f = 0; f < 2; f++) begin
            vectors++;
            if (f_valid !== 1'b1 || f_a !== qa[0] || f_b !== qb[0] || f_len !== CW'(qlen[0])) begin
                miscompares++;
                $display("FAIL bp_drain%0d: f_valid=%b f_len=%0d f_a=%h expected %h", f, f_valid, f_len, f_a, qa[0]);
            end
            idle(1'b1);
        end
    endtask

    task automatic test_pingpong();
        bit acc;
        int released = 0;
        for (int i = 0; i < 3 * N + 1; i++) begin
            vectors++;
            if (s_ready !== 1'b1 || f_valid !== (qa.size() > 0)) begin
                miscompares++;
                $display("FAIL pp_hs: cycle %0d s_ready=%b f_valid=%b expected 1 %b", i, s_ready, f_valid, qa.size() > 0);
            end
            if (qa.size() > 0) begin
                vectors++;
                released++;
                if (f_a !== qa[0] || f_b !== qb[0] || f_len !== CW'(N) || f_short !== 1'b0) begin
                    miscompares++;
                    $display("FAIL pp_frame: cycle %0d f_len=%0d f_a=%h expected %h", i, f_len, f_a, qa[0]);
                end
            end
            cycle(i < 3 * N, W'($urandom), W'($urandom), 1'b0, 1'b1, acc);
        end
        vectors++;
        if (released !== 3 || f_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pp_count: released=%0d f_valid=%b expected 3 0", released, f_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N + 10; i++) send_beat(W'($urandom), W'($urandom), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (f_valid !== 1'b0 || s_ready !== 1'b1 || f_a !== '0 || f_b !== '0 || f_len !== '0 || f_short !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: f_valid=%b s_ready=%b f_len=%0d f_short=%b", f_valid, s_ready, f_len, f_short);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) send_beat(W'($urandom), W'($urandom), 1'b0, 1'b0);
        vectors++;
        if (f_valid !== 1'b1 || f_a !== qa[0] || f_b !== qb[0] || f_len !== CW'(N)) begin
            miscompares++;
            $display("FAIL mid_recapture: f_valid=%b f_len=%0d f_a=%h expected %h", f_valid, f_len, f_a, qa[0]);
        end
        idle(1'b1);
    endtask

    task automatic test_random();
        bit acc = 1'b1;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        bit last = 1'b0;
        bit v = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (acc || !v) begin
                v    = ($urandom_range(0, 9) < 7);
                a    = W'($urandom);
                b    = W'($urandom);
                last = ($urandom_range(0, 9) == 0);
            end
            vectors++;
            if (f_valid !== (qa.size() > 0) || s_ready !== (qa.size() < 2)) begin
                miscompares++;
                $display("FAIL rnd_hs: cycle %0d f_valid=%b s_ready=%b expected %b %b", c, f_valid, s_ready, qa.size() > 0, qa.size() < 2);
            end
            if (qa.size() > 0) begin
                vectors++;
                if (f_a !== qa[0] || f_b !== qb[0] || f_len !== CW'(qlen[0]) || f_short !== (qlen[0] < N)) begin
                    miscompares++;
                    $display("FAIL rnd_frame: cycle %0d f_len=%0d f_short=%b expected %0d", c, f_len, f_short, qlen[0]);
                end
            end
            cycle(v, a, b, last, ($urandom_range(0, 9) < 3), acc);
        end
        for (int k = 0; k < 3; k++) idle(1'b1);
    endtask

`ifdef CONV_LOADER_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        vectors++;
        if (stat_frames !== 16'd0 || stat_short !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_reset: frames=%0d short=%0d expected 0 0", stat_frames, stat_short);
        end
        rst_n = 1'b1;
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < ((f < 3) ? N : 3); i++)
                send_beat(W'($urandom), W'($urandom), (f >= 3) && (i == 2), 1'b0);
            idle(1'b1);
        end
        vectors++;
        if (stat_frames !== 16'd5 || stat_short !== 16'd2) begin
            miscompares++;
            $display("FAIL stats_count: frames=%0d short=%0d expected 5 2", stat_frames, stat_short);
        end
    endtask
`endif

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_full_frame();
        test_short_frame();
        test_backpressure();
        test_pingpong();
        test_reset_mid();
        test_random();
`ifdef CONV_LOADER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
